// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between decoder, ALU and writeback for alu_pipe.
// The master side is the environment (decoder plus downstream); the slave side is the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  operation;
  logic [WIDTH-1:0] decoder_operand0;
  logic [WIDTH-1:0] decoder_operand1;
  logic [WIDTH-1:0] mem_wr_data;
  logic [1:0]       sel;
  logic             update_flags;
  logic             NOP;
  logic             clr_q;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_op;
  logic [3:0]       flags;
  logic             q_flag;

  modport master (
    output in_valid, operation, decoder_operand0, decoder_operand1, mem_wr_data,
           sel, update_flags, NOP, clr_q, out_ready,
    input  in_ready, out_valid, alu_op, flags, q_flag
  );

  modport slave (
    input  in_valid, operation, decoder_operand0, decoder_operand1, mem_wr_data,
           sel, update_flags, NOP, clr_q, out_ready,
    output in_ready, out_valid, alu_op, flags, q_flag
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered-output ALU with valid/ready on both sides, NZCV flags, sticky Q,
// saturating add/sub, carry-in ops and last-result forwarding on operand B.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_pipe_if.slave    bus
);

  typedef enum logic [3:0] {
    OP_AND  = 4'h0,
    OP_EOR  = 4'h1,
    OP_SUB  = 4'h2,
    OP_RSB  = 4'h3,
    OP_ADD  = 4'h4,
    OP_ADC  = 4'h5,
    OP_SBC  = 4'h6,
    OP_QADD = 4'h7,
    OP_QSUB = 4'h8,
    OP_ORR  = 4'h9,
    OP_MOV  = 4'hA,
    OP_BIC  = 4'hB,
    OP_CMP  = 4'hC,
    OP_CMN  = 4'hD,
    OP_RSV0 = 4'hE,
    OP_RSV1 = 4'hF
  } op_e;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_op_q, alu_op_d;
  logic [3:0]       flags_q, flags_d;
  logic             q_flag_q, q_flag_d;

  op_e              op;
  logic             accept;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic             sum_c, sum_v;
  logic [WIDTH-1:0] res;
  logic             is_arith, is_sat, is_cmp, produces;
  logic             write_flags, sat_hit;

  assign op          = op_e'(bus.operation[3:0]);
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept      = bus.in_valid && bus.in_ready;
  assign opa         = bus.decoder_operand0;

  // alu_op_q only loads on produced results and resets to 0, so it doubles as
  // the forwarding register and keeps its value after the result drains.
  always_comb begin
    unique case (bus.sel)
      2'b01:   opb = alu_op_q;
      2'b10:   opb = bus.mem_wr_data;
      default: opb = bus.decoder_operand1;
    endcase
  end

  always_comb begin
    add_x    = opa;
    add_y    = opb;
    add_cin  = 1'b0;
    is_arith = 1'b0;
    is_sat   = 1'b0;
    is_cmp   = 1'b0;
    produces = 1'b1;
    res      = '0;

    unique case (op)
      OP_ADD, OP_CMN, OP_QADD: is_arith = 1'b1;
      OP_ADC: begin
        is_arith = 1'b1;
        add_cin  = flags_q[1];
      end
      OP_SUB, OP_CMP, OP_QSUB: begin
        is_arith = 1'b1;
        add_y    = ~opb;
        add_cin  = 1'b1;
      end
      OP_SBC: begin
        is_arith = 1'b1;
        add_y    = ~opb;
        add_cin  = flags_q[1];
      end
      OP_RSB: begin
        is_arith = 1'b1;
        add_x    = opb;
        add_y    = ~opa;
        add_cin  = 1'b1;
      end
      default: ;
    endcase

    // One shared adder; subtract is x + ~y + 1 so carry-out means no borrow.
    sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    sum_c = sum[WIDTH];
    sum_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

    unique case (op)
      OP_AND:  res = opa & opb;
      OP_EOR:  res = opa ^ opb;
      OP_ORR:  res = opa | opb;
      OP_MOV:  res = opb;
      OP_BIC:  res = opa & ~opb;
      OP_QADD, OP_QSUB: begin
        is_sat = 1'b1;
        res    = sum_v ? (add_x[WIDTH-1] ? SAT_MIN : SAT_MAX) : sum[WIDTH-1:0];
      end
      OP_CMP, OP_CMN: begin
        is_cmp   = 1'b1;
        produces = 1'b0;
        res      = sum[WIDTH-1:0];
      end
      OP_RSV0, OP_RSV1: produces = 1'b0;
      default: res = sum[WIDTH-1:0];
    endcase

    if (bus.NOP) begin
      produces = 1'b0;
      is_cmp   = 1'b0;
      is_sat   = 1'b0;
    end
  end

  assign write_flags = accept && ((produces && bus.update_flags) || is_cmp);
  assign sat_hit     = accept && produces && is_sat && sum_v;

  always_comb begin
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    flags_d     = flags_q;
    q_flag_d    = q_flag_q;

    if (bus.in_ready) begin
      out_valid_d = accept && produces;
    end
    if (accept && produces) begin
      alu_op_d = res;
    end
    if (write_flags) begin
      flags_d[3] = res[WIDTH-1];
      flags_d[2] = (res == '0);
      if (is_arith) begin
        flags_d[1] = sum_c;
        flags_d[0] = sum_v;
      end
    end
    // Saturation beats a simultaneous clear.
    if (sat_hit) begin
      q_flag_d = 1'b1;
    end else if (bus.clr_q) begin
      q_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= '0;
      flags_q     <= '0;
      q_flag_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      flags_q     <= flags_d;
      q_flag_q    <= q_flag_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.flags     = flags_q;
  assign bus.q_flag    = q_flag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe with hand-computed expected results.
module tb_alu_pipe;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_pipe_if #(.WIDTH(32), .OP_W(4)) bus ();

  alu_pipe #(.WIDTH(32), .OP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] s, input logic uf, input logic nop);
    bus.operation        = op;
    bus.decoder_operand0 = a;
    bus.decoder_operand1 = b;
    bus.sel              = s;
    bus.update_flags     = uf;
    bus.NOP              = nop;
    bus.in_valid         = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid     = 1'b0;
    bus.update_flags = 1'b0;
    bus.NOP          = 1'b0;
    bus.clr_q        = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.operation = 0; bus.decoder_operand0 = 0;
    bus.decoder_operand1 = 0; bus.mem_wr_data = 0; bus.sel = 0;
    bus.update_flags = 0; bus.NOP = 0; bus.clr_q = 0; bus.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_alu",   bus.alu_op, 32'd0);
    chk("rst_flags", {28'b0, bus.flags}, 32'd0);
    chk("rst_q",     {31'b0, bus.q_flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // throughput
    issue(4'h4, 32'd5, 32'd7, 2'b00, 1'b0, 1'b0);
    chk("add_res",   bus.alu_op, 32'd12);
    chk("add_valid", {31'b0, bus.out_valid}, 32'd1);
    issue(4'h2, 32'd3, 32'd5, 2'b00, 1'b1, 1'b0);
    chk("sub_res",   bus.alu_op, 32'hFFFF_FFFE);
    chk("sub_flags", {28'b0, bus.flags}, 32'h8);
    @(posedge clk); #1;
    chk("drain_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("drain_hold",  bus.alu_op, 32'hFFFF_FFFE);

    // backpressure
    bus.out_ready = 1'b0;
    issue(4'h4, 32'd10, 32'd20, 2'b00, 1'b0, 1'b0);
    chk("bp_res", bus.alu_op, 32'd30);
    bus.operation = 4'h4; bus.decoder_operand0 = 1; bus.decoder_operand1 = 1;
    bus.sel = 2'b00; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_inready", {31'b0, bus.in_ready}, 32'd0);
      chk("bp_hold",    bus.alu_op, 32'd30);
      chk("bp_valid",   {31'b0, bus.out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_next", bus.alu_op, 32'd2);

    // forwarding
    issue(4'h4, 32'd1, 32'd1, 2'b00, 1'b0, 1'b0);
    chk("fwd_base", bus.alu_op, 32'd2);
    issue(4'h4, 32'd3, 32'hDEAD_BEEF, 2'b01, 1'b0, 1'b0);
    chk("fwd_last", bus.alu_op, 32'd5);
    bus.mem_wr_data = 32'd9;
    issue(4'h4, 32'd3, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0);
    chk("fwd_mem", bus.alu_op, 32'd12);

    // saturation
    issue(4'h7, 32'h7FFF_FFFF, 32'd1, 2'b00, 1'b1, 1'b0);
    chk("qadd_res",   bus.alu_op, 32'h7FFF_FFFF);
    chk("qadd_q",     {31'b0, bus.q_flag}, 32'd1);
    chk("qadd_flags", {28'b0, bus.flags}, 32'h1);
    issue(4'h8, 32'h8000_0000, 32'd1, 2'b00, 1'b1, 1'b0);
    chk("qsub_res",   bus.alu_op, 32'h8000_0000);
    chk("qsub_flags", {28'b0, bus.flags}, 32'hB);
    bus.clr_q = 1'b1;
    @(posedge clk); #1;
    bus.clr_q = 1'b0;
    chk("clrq", {31'b0, bus.q_flag}, 32'd0);
    issue(4'h7, 32'd100, 32'd23, 2'b00, 1'b0, 1'b0);
    chk("qadd_nosat", bus.alu_op, 32'd123);
    chk("q_nosat",    {31'b0, bus.q_flag}, 32'd0);
    bus.clr_q = 1'b1;
    issue(4'h7, 32'h7FFF_FFFF, 32'd1, 2'b00, 1'b0, 1'b0);
    chk("q_setwins", {31'b0, bus.q_flag}, 32'd1);

    // carry chain and remaining ops
    issue(4'h4, 32'hFFFF_FFFF, 32'd1, 2'b00, 1'b1, 1'b0);
    chk("carry_res",   bus.alu_op, 32'd0);
    chk("carry_flags", {28'b0, bus.flags}, 32'h6);
    issue(4'h5, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
    chk("adc_res",   bus.alu_op, 32'd1);
    chk("adc_flags", {28'b0, bus.flags}, 32'h6);
    issue(4'h6, 32'd5, 32'd3, 2'b00, 1'b1, 1'b0);
    chk("sbc_res",   bus.alu_op, 32'd2);
    chk("sbc_flags", {28'b0, bus.flags}, 32'h2);
    issue(4'h1, 32'h8000_0000, 32'd0, 2'b00, 1'b1, 1'b0);
    chk("eor_res",   bus.alu_op, 32'h8000_0000);
    chk("eor_flags", {28'b0, bus.flags}, 32'hA);
    issue(4'h3, 32'd3, 32'd10, 2'b00, 1'b0, 1'b0);
    chk("rsb", bus.alu_op, 32'd7);
    issue(4'hB, 32'hFF, 32'h0F, 2'b00, 1'b0, 1'b0);
    chk("bic", bus.alu_op, 32'hF0);
    issue(4'h0, 32'hF0F0, 32'hFF00, 2'b00, 1'b0, 1'b0);
    chk("and", bus.alu_op, 32'hF000);
    issue(4'h9, 32'hF0F0, 32'hFF00, 2'b00, 1'b0, 1'b0);
    chk("orr", bus.alu_op, 32'hFFF0);
    issue(4'hA, 32'd0, 32'h1234, 2'b00, 1'b0, 1'b0);
    chk("mov", bus.alu_op, 32'h1234);

    // no-output ops
    issue(4'hC, 32'd4, 32'd4, 2'b00, 1'b0, 1'b0);
    chk("cmp_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("cmp_flags", {28'b0, bus.flags}, 32'h6);
    chk("cmp_alu",   bus.alu_op, 32'h1234);
    issue(4'h4, 32'd1, 32'd1, 2'b00, 1'b1, 1'b1);
    chk("nop_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("nop_flags", {28'b0, bus.flags}, 32'h6);
    issue(4'hE, 32'd1, 32'd1, 2'b00, 1'b1, 1'b0);
    chk("rsv_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rsv_flags", {28'b0, bus.flags}, 32'h6);
    issue(4'h4, 32'd0, 32'd0, 2'b01, 1'b0, 1'b0);
    chk("nop_last", bus.alu_op, 32'h1234);
    issue(4'hD, 32'h7FFF_FFFF, 32'd1, 2'b00, 1'b0, 1'b0);
    chk("cmn_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("cmn_flags", {28'b0, bus.flags}, 32'h9);

    // async reset mid-op
    bus.operation = 4'h4; bus.decoder_operand0 = 1; bus.decoder_operand1 = 2;
    bus.sel = 2'b00; bus.in_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("arst_alu",   bus.alu_op, 32'd0);
    chk("arst_flags", {28'b0, bus.flags}, 32'd0);
    chk("arst_q",     {31'b0, bus.q_flag}, 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_noreplay", {31'b0, bus.out_valid}, 32'd0);
    issue(4'h4, 32'd0, 32'hFFFF, 2'b01, 1'b0, 1'b0);
    chk("arst_last", bus.alu_op, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
